// File: rtl/rv32i_mc_ctrl.sv
// rv32i_mc_ctrl: multi-cycle control FSM for the RV32I core.
// Steps one shared ALU, one memory port and the register file through
// FETCH / DECODE / EXECUTE / BR_TGT / MEM / WB, traps on unsupported
// encodings, and counts retired instructions.
// Ports:
//   clk, rst            core clock (rising edge), async active-high reset
//   opcode_i, funct3_i, funct7_5_i  instruction register fields
//   alu_zero_i          ALU result == 0
//   mem_ready_i         memory completes the current request this cycle
//   mem_req_o/mem_we_o/addr_sel_o   memory port control
//   ir_we_o, ab_we_o, pc_we_o, pc_src_o, rf_we_o, wb_sel_o  datapath enables/muxes
//   alu_op_o, alu_src_a_o, alu_src_b_o  ALU control
//   illegal_o           sticky unsupported-instruction flag
//   retired_o           retired instruction count (wraps)
module rv32i_mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7_5_i,
  input  logic        alu_zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        addr_sel_o,
  output logic        ir_we_o,
  output logic        ab_we_o,
  output logic        pc_we_o,
  output logic        pc_src_o,
  output logic [2:0]  alu_op_o,
  output logic        alu_src_a_o,
  output logic        alu_src_b_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        illegal_o,
  output logic [31:0] retired_o
);

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_BR_TGT  = 3'd3;
  localparam logic [2:0] S_MEM     = 3'd4;
  localparam logic [2:0] S_WB      = 3'd5;
  localparam logic [2:0] S_TRAP    = 3'd6;

  // opcode_fmt_t encodings; STALL is the all-zero opcode (pipeline bubble / NOP)
  localparam logic [6:0] OP_STALL  = 7'b0000000;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_SUM = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] retired_q, retired_d;
  logic            legal;
  logic            arith_f3_ok;
  logic [2:0]      arith_op;

  // Decode: legality of the current encoding and the REG/IMM ALU mapping
  always_comb begin
    arith_f3_ok = (funct3_i == 3'b000) || (funct3_i == 3'b111) ||
                  (funct3_i == 3'b110) || (funct3_i == 3'b010);
    case (funct3_i)
      3'b111:  arith_op = ALU_AND;
      3'b110:  arith_op = ALU_OR;
      3'b010:  arith_op = ALU_SLT;
      // funct7_5 selects SUB only for register-register ops
      default: arith_op = (opcode_i == OP_REG && funct7_5_i) ? ALU_SUB : ALU_SUM;
    endcase
    case (opcode_i)
      OP_REG, OP_IMM:           legal = arith_f3_ok;
      OP_LOAD, OP_STORE:        legal = (funct3_i == 3'b010);
      OP_BRANCH:                legal = (funct3_i[2:1] == 2'b00);
      OP_JALR:                  legal = (funct3_i == 3'b000);
      OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                  legal = 1'b0;
    endcase
  end

  // Next state and Moore outputs (FETCH enables and MEM exit also see mem_ready)
  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    addr_sel_o  = 1'b0;
    ir_we_o     = 1'b0;
    ab_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_src_o    = 1'b0;
    alu_op_o    = ALU_SUM;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 1'b0;
    rf_we_o     = 1'b0;
    wb_sel_o    = 2'b00;
    illegal_o   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ab_we_o = 1'b1;
        if (opcode_i == OP_STALL) state_d = S_FETCH;
        else if (!legal)          state_d = S_TRAP;
        else                      state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = S_FETCH;
        case (opcode_i)
          OP_REG: begin
            alu_op_o = arith_op;
            state_d  = S_WB;
          end
          OP_IMM: begin
            alu_op_o    = arith_op;
            alu_src_b_o = 1'b1;
            state_d     = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b_o = 1'b1;
            state_d     = S_MEM;
          end
          OP_BRANCH: begin
            alu_op_o = ALU_SUB;
            // BEQ taken on zero, BNE (funct3[0]=1) taken on non-zero
            if (alu_zero_i ^ funct3_i[0]) state_d = S_BR_TGT;
          end
          OP_JAL, OP_JALR: begin
            alu_src_a_o = (opcode_i == OP_JAL);
            alu_src_b_o = 1'b1;
            pc_we_o     = 1'b1;
            pc_src_o    = 1'b1;
            rf_we_o     = 1'b1;
            wb_sel_o    = 2'b10;
          end
          OP_LUI: begin
            rf_we_o  = 1'b1;
            wb_sel_o = 2'b11;
          end
          OP_AUIPC: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 1'b1;
            state_d     = S_WB;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_BR_TGT: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 1'b1;
        pc_we_o     = 1'b1;
        pc_src_o    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM: begin
        mem_req_o  = 1'b1;
        addr_sel_o = 1'b1;
        mem_we_o   = (opcode_i == OP_STORE);
        if (mem_ready_i) state_d = (opcode_i == OP_LOAD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        rf_we_o  = 1'b1;
        wb_sel_o = (opcode_i == OP_LOAD) ? 2'b01 : 2'b00;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        illegal_o = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Every output is forced low while reset is held, with no clock needed
    if (rst) begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      addr_sel_o  = 1'b0;
      ir_we_o     = 1'b0;
      ab_we_o     = 1'b0;
      pc_we_o     = 1'b0;
      pc_src_o    = 1'b0;
      alu_op_o    = ALU_SUM;
      alu_src_a_o = 1'b0;
      alu_src_b_o = 1'b0;
      rf_we_o     = 1'b0;
      wb_sel_o    = 2'b00;
      illegal_o   = 1'b0;
    end
  end

  // An instruction retires whenever control returns to FETCH from elsewhere
  always_comb begin
    retired_d = retired_q;
    if (state_q != S_FETCH && state_d == S_FETCH) retired_d = retired_q + XLEN'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired_o = retired_q;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
module tb_rv32i_mc_ctrl;

  localparam logic [6:0] OP_STALL  = 7'h00;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic        funct7_5_i = 1'b0;
  logic        alu_zero_i = 1'b0;
  logic        mem_ready_i = 1'b0;
  logic        mem_req_o, mem_we_o, addr_sel_o, ir_we_o, ab_we_o, pc_we_o, pc_src_o;
  logic [2:0]  alu_op_o;
  logic        alu_src_a_o, alu_src_b_o, rf_we_o, illegal_o;
  logic [1:0]  wb_sel_o;
  logic [31:0] retired_o;

  int checks = 0;
  int passed = 0;

  rv32i_mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .funct7_5_i(funct7_5_i), .alu_zero_i(alu_zero_i), .mem_ready_i(mem_ready_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .addr_sel_o(addr_sel_o),
    .ir_we_o(ir_we_o), .ab_we_o(ab_we_o), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o),
    .alu_op_o(alu_op_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o), .illegal_o(illegal_o), .retired_o(retired_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] all_outs();
    return {mem_req_o, mem_we_o, addr_sel_o, ir_we_o, ab_we_o, pc_we_o, pc_src_o,
            alu_op_o, alu_src_a_o, alu_src_b_o, rf_we_o, wb_sel_o, illegal_o};
  endfunction

  // Reference: ALU op named by the instruction's arithmetic rule
  function automatic logic [2:0] ref_arith(input logic [2:0] f3, input logic f7, input logic is_reg);
    if (f3 == 3'b111) return 3'b010;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b010) return 3'b101;
    return (is_reg && f7) ? 3'b001 : 3'b000;
  endfunction

  // Runs one legal instruction and compares its observed footprint with the reference
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input int fw, input int mw);
    int ecyc, erf, epc, ewe, emc;
    logic [1:0] ewb;
    logic epsrc, esa, esb, stall, jump, taken, is_mem;
    logic [2:0] eop;
    int cyc, fcnt, mcnt, nrf, npc, nwe, nir;
    logic [1:0] wbs;
    logic psrc, sa, sb, done;
    logic [2:0] xop;
    logic [31:0] start;

    stall  = (op == OP_STALL);
    jump   = (op == OP_JAL) || (op == OP_JALR);
    taken  = (op == OP_BRANCH) && (z ^ f3[0]);
    is_mem = (op == OP_LOAD) || (op == OP_STORE);
    if (stall) ecyc = 2;
    else if (jump || op == OP_LUI || (op == OP_BRANCH && !taken)) ecyc = 3;
    else if (op == OP_LOAD) ecyc = 5;
    else ecyc = 4;
    ecyc = ecyc + fw + (is_mem ? mw : 0);
    erf  = (op == OP_REG || op == OP_IMM || op == OP_AUIPC || op == OP_LOAD || jump || op == OP_LUI) ? 1 : 0;
    ewb  = (op == OP_LOAD) ? 2'b01 : jump ? 2'b10 : (op == OP_LUI) ? 2'b11 : 2'b00;
    epc  = 1 + ((jump || taken) ? 1 : 0);
    epsrc = jump || taken;
    ewe  = (op == OP_STORE) ? mw + 1 : 0;
    emc  = is_mem ? mw + 1 : 0;
    eop  = (op == OP_REG) ? ref_arith(f3, f7, 1'b1) : (op == OP_IMM) ? ref_arith(f3, f7, 1'b0) :
           (op == OP_BRANCH) ? 3'b001 : 3'b000;
    esa  = (op == OP_JAL) || (op == OP_AUIPC);
    esb  = (op == OP_IMM) || is_mem || jump || (op == OP_AUIPC);

    opcode_i = op; funct3_i = f3; funct7_5_i = f7; alu_zero_i = z;
    start = retired_o;
    cyc = 0; fcnt = 0; mcnt = 0; nrf = 0; npc = 0; nwe = 0; nir = 0;
    wbs = 2'b00; psrc = 1'b0; sa = 1'b0; sb = 1'b0; xop = 3'b000; done = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      if (mem_req_o && !addr_sel_o) begin
        mem_ready_i = (fcnt == fw); fcnt++;
      end else if (mem_req_o && addr_sel_o) begin
        mem_ready_i = (mcnt == mw); mcnt++;
        if (mem_we_o) nwe++;
      end else begin
        mem_ready_i = 1'($urandom_range(0, 1));
      end
      #1;
      if (rf_we_o) begin nrf++; wbs = wb_sel_o; end
      if (pc_we_o) begin npc++; psrc = pc_src_o; end
      if (ir_we_o) nir++;
      if (cyc == fw + 2) begin xop = alu_op_o; sa = alu_src_a_o; sb = alu_src_b_o; end
      cyc++;
      @(posedge clk); #1;
      if (retired_o != start) done = 1'b1;
    end
    mem_ready_i = 1'b0;

    checks++; if (!done) $display("FAIL %s timeout: no retire within %0d cycles", name, cyc); else passed++;
    checks++; if (cyc !== ecyc) $display("FAIL %s cycles got %0d exp %0d", name, cyc, ecyc); else passed++;
    checks++; if (retired_o !== start + 32'd1) $display("FAIL %s retired got %0h exp %0h", name, retired_o, start + 32'd1); else passed++;
    checks++; if (nrf !== erf) $display("FAIL %s rf_we cycles got %0d exp %0d", name, nrf, erf); else passed++;
    if (erf > 0) begin
      checks++; if (wbs !== ewb) $display("FAIL %s wb_sel got %b exp %b", name, wbs, ewb); else passed++;
    end
    checks++; if (npc !== epc) $display("FAIL %s pc_we cycles got %0d exp %0d", name, npc, epc); else passed++;
    checks++; if (psrc !== epsrc) $display("FAIL %s last pc_src got %b exp %b", name, psrc, epsrc); else passed++;
    checks++; if (nir !== 1) $display("FAIL %s ir_we cycles got %0d exp 1", name, nir); else passed++;
    checks++; if (nwe !== ewe) $display("FAIL %s mem_we cycles got %0d exp %0d", name, nwe, ewe); else passed++;
    checks++; if (mcnt !== emc) $display("FAIL %s data mem_req cycles got %0d exp %0d", name, mcnt, emc); else passed++;
    if (!stall) begin
      checks++; if (xop !== eop) $display("FAIL %s execute alu_op got %b exp %b", name, xop, eop); else passed++;
      checks++; if ({sa, sb} !== {esa, esb}) $display("FAIL %s execute src_a/b got %b exp %b", name, {sa, sb}, {esa, esb}); else passed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (all_outs() !== 16'h0) $display("FAIL reset outputs got %h exp 0", all_outs()); else passed++;
    checks++; if (retired_o !== 32'h0) $display("FAIL reset retired got %h exp 0", retired_o); else passed++;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if ({mem_req_o, addr_sel_o} !== 2'b10) $display("FAIL reset release mem_req/addr_sel got %b exp 10", {mem_req_o, addr_sel_o}); else passed++;
  endtask

  task automatic test_directed();
    run_instr("ADD",  OP_REG,    3'b000, 1'b0, 1'b0, 0, 0);
    run_instr("SUB",  OP_REG,    3'b000, 1'b1, 1'b0, 0, 0);
    run_instr("SLTI", OP_IMM,    3'b010, 1'b1, 1'b0, 1, 0);
    run_instr("BEQ",  OP_BRANCH, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr("BNE",  OP_BRANCH, 3'b001, 1'b0, 1'b1, 0, 0);
    run_instr("LW",   OP_LOAD,   3'b010, 1'b0, 1'b0, 0, 3);
    run_instr("SW",   OP_STORE,  3'b010, 1'b0, 1'b0, 0, 1);
    run_instr("JAL",  OP_JAL,    3'b101, 1'b0, 1'b0, 0, 0);
    run_instr("JALR", OP_JALR,   3'b000, 1'b0, 1'b0, 2, 0);
    run_instr("LUI",  OP_LUI,    3'b011, 1'b0, 1'b0, 0, 0);
    run_instr("AUIPC", OP_AUIPC, 3'b100, 1'b0, 1'b0, 0, 0);
    run_instr("STALL", OP_STALL, 3'b000, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [6:0] op;
    logic [2:0] f3;
    logic [2:0] arith_f3 [4] = '{3'b000, 3'b111, 3'b110, 3'b010};
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: begin op = OP_REG;    f3 = arith_f3[$urandom_range(0, 3)]; end
        1: begin op = OP_IMM;    f3 = arith_f3[$urandom_range(0, 3)]; end
        2: begin op = OP_LOAD;   f3 = 3'b010; end
        3: begin op = OP_STORE;  f3 = 3'b010; end
        4: begin op = OP_BRANCH; f3 = 3'($urandom_range(0, 1)); end
        5: op = OP_JAL;
        6: begin op = OP_JALR;   f3 = 3'b000; end
        7: op = OP_LUI;
        8: op = OP_AUIPC;
        default: op = OP_STALL;
      endcase
      run_instr("RAND", op, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    mem_ready_i = 1'b0;
    force dut.retired_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retired_q;
    @(negedge clk);
    checks++; if (retired_o !== 32'hFFFF_FFFF) $display("FAIL wrap preload got %h exp ffffffff", retired_o); else passed++;
    run_instr("WRAP", OP_STALL, 3'b000, 1'b0, 1'b0, 0, 0);
    checks++; if (retired_o !== 32'h0) $display("FAIL wrap retired got %h exp 0", retired_o); else passed++;
  endtask

  task automatic test_trap();
    int nreq, npc;
    logic [31:0] start;
    opcode_i = OP_REG; funct3_i = 3'b001; funct7_5_i = 1'b0;
    start = retired_o; nreq = 0; npc = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      mem_ready_i = 1'b1;
      #1;
      if (mem_req_o) nreq++;
      if (pc_we_o || rf_we_o) npc++;
      if (c >= 2) begin
        opcode_i = 7'($urandom); funct3_i = 3'($urandom);
      end
    end
    #1;
    checks++; if (illegal_o !== 1'b1) $display("FAIL trap illegal got %b exp 1", illegal_o); else passed++;
    checks++; if (nreq !== 1) $display("FAIL trap mem_req cycles got %0d exp 1", nreq); else passed++;
    checks++; if (npc !== 1) $display("FAIL trap write-enable cycles got %0d exp 1", npc); else passed++;
    checks++; if (retired_o !== start) $display("FAIL trap retired got %h exp %h", retired_o, start); else passed++;
    mem_ready_i = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (illegal_o !== 1'b0) $display("FAIL trap rst illegal got %b exp 0", illegal_o); else passed++;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if ({mem_req_o, addr_sel_o, illegal_o} !== 3'b100) $display("FAIL trap restart got %b exp 100", {mem_req_o, addr_sel_o, illegal_o}); else passed++;
  endtask

  task automatic test_reset_mid_mem();
    int guard;
    logic [15:0] outs;
    opcode_i = OP_LOAD; funct3_i = 3'b010; funct7_5_i = 1'b0;
    guard = 0;
    @(negedge clk); mem_ready_i = 1'b1; #1;
    while (!(mem_req_o && addr_sel_o) && guard < 10) begin
      @(negedge clk); mem_ready_i = 1'b1; #1; guard++;
    end
    mem_ready_i = 1'b0;
    checks++; if (!(mem_req_o && addr_sel_o)) $display("FAIL midmem never reached MEM, mem_req/addr_sel got %b", {mem_req_o, addr_sel_o}); else passed++;
    #1 rst = 1'b1;
    #1 outs = all_outs();
    checks++; if (outs !== 16'h0) $display("FAIL midmem rst outputs got %h exp 0", outs); else passed++;
    checks++; if (retired_o !== 32'h0) $display("FAIL midmem rst retired got %h exp 0", retired_o); else passed++;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if ({mem_req_o, addr_sel_o, ir_we_o} !== 3'b100) $display("FAIL midmem restart got %b exp 100", {mem_req_o, addr_sel_o, ir_we_o}); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_wrap();
    test_trap();
    run_instr("POST_TRAP_ADD", OP_REG, 3'b000, 1'b0, 1'b0, 0, 0);
    test_reset_mid_mem();
    run_instr("POST_RST_LW", OP_LOAD, 3'b010, 1'b0, 1'b0, 1, 2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
